mem_bus_master: RTL and testbench

//   Initiator side of the MEM handshake (address/dataIn/dataOut/R_W/EN/MFC).

---
 rtl/mem_bus_if.sv | 23 ++
 rtl/mem_bus_master.sv | 131 +++++++++++++
 tb/tb_mem_bus_master.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if.sv
// MEM handshake bundle between the bus master and the memory responder.
`timescale 1ns/1ps
interface mem_bus_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              R_W;
  logic              EN;
  logic              MFC;

  modport master (
    output mem_addr, mem_din, R_W, EN,
    input  mem_dout, MFC
  );

  modport slave (
    input  mem_addr, mem_din, R_W, EN,
    output mem_dout, MFC
  );
endinterface

// File: rtl/mem_bus_master.sv
// Initiator side of the MEM address/data/R_W/EN/MFC handshake.
// Optional STROBE timeout abort enabled by defining MEM_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_bus_master #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  mem_bus_if.master         bus
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_bus_master: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_STROBE  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] mfc_sync;
  logic                   mfc_s;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      din_q;
  logic                   rw_q;
  logic                   en_q;

  assign mfc_s        = mfc_sync[SYNC_STAGES-1];
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.R_W      = rw_q;
  assign bus.EN       = en_q;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // EN is registered off the STROBE state, so it rises one edge after
  // STROBE is entered, keeping a full SETUP cycle of stable address/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      mfc_sync <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      rw_q     <= 1'b1;
      en_q     <= 1'b0;
      rdata    <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt  <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      mfc_sync <= {mfc_sync[SYNC_STAGES-2:0], bus.MFC};
      done     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q <= addr;
            din_q  <= wdata;
            rw_q   <= ~wr;
            busy   <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          en_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (mfc_s) begin
            en_q  <= 1'b0;
            done  <= 1'b1;
            if (rw_q) rdata <= bus.mem_dout;
            state <= ST_RECOVER;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            en_q  <= 1'b0;
            done  <= 1'b1;
            err_q <= 1'b1;
            state <= ST_RECOVER;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            en_q    <= 1'b1;
          end
`else
          else begin
            en_q <= 1'b1;
          end
`endif
        end
        ST_RECOVER: begin
          en_q <= 1'b0;
          if (!mfc_s) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed self-checking bench for mem_bus_master with a behavioural MEM responder.
`timescale 1ns/1ps
module tb_mem_bus_master;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 255;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req = 1'b0;
  logic              wr = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              done, busy, err;

  mem_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned done_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned en_rise = 0;
  int unsigned en_stale = 0;
  logic        stuck = 1'b0;
  logic [DATA_W-1:0] mem [0:255];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory responder: MFC follows EN after a delay, drops after EN falls.
  initial begin
    bus.MFC = 1'b0;
    bus.mem_dout = '0;
    forever begin
      @(posedge bus.EN);
      if (!stuck) begin
        #7;
        if (bus.R_W) bus.mem_dout = mem[bus.mem_addr[7:0]];
        else mem[bus.mem_addr[7:0]] = bus.mem_din;
        bus.MFC = 1'b1;
        wait (bus.EN == 1'b0);
        #5;
        bus.MFC = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  always @(posedge bus.EN) begin
    en_rise++;
    if (bus.MFC) en_stale++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!busy) begin seen = 1'b1; break; end
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_en(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.EN) begin seen = 1'b1; break; end
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int unsigned d0, r0, n, hi;
    logic moved;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[3] = 16'h7245;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_en", 32'(bus.EN), 32'd0);
    check_eq("rst_rw", 32'(bus.R_W), 32'd1);
    check_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_din", 32'(bus.mem_din), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    check_eq("rst_flags", {29'd0, done, busy, err}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Read addr 3: EN latency, data, flags
    start_req(1'b0, 16'd3, 16'h0);
    check_eq("rd_busy_n", 32'(busy), 32'd1);
    check_eq("rd_en_n", 32'(bus.EN), 32'd0);
    @(posedge clk); #1;
    check_eq("rd_en_n1", 32'(bus.EN), 32'd0);
    @(posedge clk); #1;
    check_eq("rd_en_n2", 32'(bus.EN), 32'd1);
    check_eq("rd_rw", 32'(bus.R_W), 32'd1);
    wait_done("rd_done");
    check_eq("rd_data", 32'(rdata), 32'h7245);
    check_eq("rd_err", 32'(err), 32'd0);
    check_eq("rd_en_off", 32'(bus.EN), 32'd0);
    wait_idle("rd_idle");
    check_eq("rd_mfc_low", 32'(bus.MFC), 32'd0);
    check_eq("rd_done_cnt", done_cnt, 32'd1);

    // Write 10 then read back; rdata untouched by the write
    start_req(1'b1, 16'd10, 16'hBEEF);
    wait_en("wr_en");
    check_eq("wr_din", 32'(bus.mem_din), 32'hBEEF);
    check_eq("wr_rw", 32'(bus.R_W), 32'd0);
    wait_done("wr_done");
    check_eq("wr_rdata_hold", 32'(rdata), 32'h7245);
    wait_idle("wr_idle");
    check_eq("wr_mem", 32'(mem[10]), 32'hBEEF);
    start_req(1'b0, 16'd10, 16'h0);
    wait_done("rb_done");
    check_eq("rb_data", 32'(rdata), 32'hBEEF);
    wait_idle("rb_idle");

    // Back-to-back with req held high
    d0 = done_cnt; r0 = en_rise; n = 0;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 16'd3;
    for (int i = 0; i < 300 && n < 3; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    req = 1'b0;
    wait_idle("b2b_idle");
    repeat (4) @(posedge clk);
    #1;
    check_eq("b2b_done", done_cnt - d0, 32'd3);
    check_eq("b2b_en_rise", en_rise - r0, 32'd3);
    check_eq("b2b_stale", en_stale, 32'd0);

    // req during STROBE is ignored
    d0 = done_cnt;
    start_req(1'b0, 16'd3, 16'h0);
    wait_en("ign_en");
    req = 1'b1; wr = 1'b1; addr = 16'd5; wdata = 16'h1111;
    @(posedge clk); #1;
    req = 1'b0;
    check_eq("ign_addr", 32'(bus.mem_addr), 32'd3);
    wait_done("ign_done");
    wait_idle("ign_idle");
    repeat (6) @(posedge clk);
    #1;
    check_eq("ign_done_cnt", done_cnt - d0, 32'd1);
    check_eq("ign_addr_hold", 32'(bus.mem_addr), 32'd3);
    check_eq("ign_rw_hold", 32'(bus.R_W), 32'd1);

    // MFC high while idle changes nothing
    d0 = done_cnt; moved = 1'b0;
    @(negedge clk); bus.MFC = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.EN || busy || done) moved = 1'b1;
    end
    bus.MFC = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("idle_mfc_quiet", 32'(moved), 32'd0);
    check_eq("idle_mfc_done", done_cnt - d0, 32'd0);

    // Reset while EN is high
    stuck = 1'b1;
    d0 = done_cnt;
    start_req(1'b0, 16'd10, 16'h0);
    wait_en("rst_mid_en");
    #2; reset = 1'b1; #1;
    check_eq("rst_mid_en_off", 32'(bus.EN), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0; stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mid_no_done", done_cnt - d0, 32'd0);
    start_req(1'b0, 16'd3, 16'h0);
    wait_done("post_rst_done");
    check_eq("post_rst_data", 32'(rdata), 32'h7245);
    wait_idle("post_rst_idle");

`ifdef MEM_TIMEOUT_EN
    // Stuck MFC aborts after the configured STROBE count
    stuck = 1'b1;
    d0 = done_cnt; hi = 0;
    start_req(1'b0, 16'd10, 16'h0);
    wait_en("tmo_en");
    hi = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!bus.EN) break;
      hi++;
    end
    check_eq("tmo_en_cycles", hi, TMO);
    check_eq("tmo_done", 32'(done), 32'd1);
    check_eq("tmo_err", 32'(err), 32'd1);
    check_eq("tmo_rdata", 32'(rdata), 32'h7245);
    @(posedge clk); #1;
    check_eq("tmo_err_pulse", 32'(err), 32'd0);
    wait_idle("tmo_idle");
    check_eq("tmo_err_cnt", err_cnt, 32'd1);
    stuck = 1'b0;
`else
    check_eq("err_tied", err_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
